// File: rtl/pipe_series_ctrl.sv
// pipe_series_ctrl: upstream sequencer for the 4-stage series pipeline.
// Accepts one operand and recirculates it through the pipeline N_PASSES times.
// It returns the final sum and a sticky overflow flag.
// Optional macro PIPE_SERIES_SAT_EN: saturate out_result when out_ovf is set.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready/in_x         operand handshake
//   out_valid/out_ready            result handshake
//   out_result/out_ovf             result and overflow flag
//   busy                           controller is not idle
//   pipe_x/num/sum/addr/sel_sum    drive the pipeline inputs
//   pipe_out_x/num/sum, pipe_ovf   pipeline stage-4 outputs
module pipe_series_ctrl #(
    parameter int WIDTH    = 32,
    parameter int N_PASSES = 2,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf,
    output logic             busy,
    output logic [WIDTH-1:0] pipe_x,
    output logic [WIDTH-1:0] pipe_num,
    output logic [WIDTH-1:0] pipe_sum,
    output logic             pipe_addr,
    output logic             pipe_sel_sum,
    input  logic [WIDTH-1:0] pipe_out_x,
    input  logic [WIDTH-1:0] pipe_out_num,
    input  logic [WIDTH-1:0] pipe_out_sum,
    input  logic             pipe_ovf
);

    localparam int CW = $clog2(PIPE_LAT + 1);
    localparam int PW = 2;
    localparam logic [CW-1:0] LAT  = CW'(PIPE_LAT);
    localparam logic [PW-1:0] LAST = PW'(N_PASSES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [PW-1:0]    pass;
    logic             ovf;
    logic             accept;
    logic             capture;
    logic             last_pass;
    logic             final_ovf;
    logic [WIDTH-1:0] result_nxt;

    assign accept    = in_valid & in_ready;
    assign capture   = (state == RUN) && (cnt == LAT);
    assign last_pass = (pass == LAST);
    assign final_ovf = ovf | pipe_ovf;
    assign busy      = (state != IDLE);
    // One address drives every stage, so it only changes between passes.
    assign pipe_addr = pass[0];

`ifdef PIPE_SERIES_SAT_EN
    always_comb begin
        result_nxt = pipe_out_sum;
        if (final_ovf) begin
            result_nxt = pipe_out_sum[WIDTH-1]
                ? {1'b1, {(WIDTH-1){1'b0}}}
                : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign result_nxt = pipe_out_sum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        pipe_sel_sum = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                pipe_sel_sum = 1'b1;
                if (capture && last_pass) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_x     <= '0;
            pipe_num   <= '0;
            pipe_sum   <= '0;
            pass       <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
        end else if (accept) begin
            pipe_x   <= in_x;
            pipe_num <= in_x;
            pipe_sum <= '0;
            pass     <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else if (state == RUN) begin
            if (capture) begin
                ovf <= final_ovf;
                cnt <= '0;
                if (!last_pass) begin
                    pipe_x   <= pipe_out_x;
                    pipe_num <= pipe_out_num;
                    pipe_sum <= pipe_out_sum;
                    pass     <= pass + 1'b1;
                end else begin
                    out_result <= result_nxt;
                    out_ovf    <= final_ovf;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_series_ctrl.sv
// tb_pipe_series_ctrl: directed bench for pipe_series_ctrl with a
// 3-edge pipeline model (out_num = num+x, out_sum = sum + num*(addr?2:1)).
module tb_pipe_series_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        busy;
    logic [31:0] pipe_x, pipe_num, pipe_sum;
    logic        pipe_addr, pipe_sel_sum;
    logic [31:0] pipe_out_x, pipe_out_num, pipe_out_sum;
    logic        pipe_ovf;
    logic        ovf_inject;

    logic [31:0] m1_x, m1_num, m1_sum;
    logic [31:0] m2_x, m2_num, m2_sum;
    logic [31:0] m3_x, m3_num, m3_sum;

    int checks = 0;
    int errors = 0;

    pipe_series_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_ovf      (out_ovf),
        .busy         (busy),
        .pipe_x       (pipe_x),
        .pipe_num     (pipe_num),
        .pipe_sum     (pipe_sum),
        .pipe_addr    (pipe_addr),
        .pipe_sel_sum (pipe_sel_sum),
        .pipe_out_x   (pipe_out_x),
        .pipe_out_num (pipe_out_num),
        .pipe_out_sum (pipe_out_sum),
        .pipe_ovf     (pipe_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m1_x   <= pipe_x;
        m1_num <= pipe_num + pipe_x;
        m1_sum <= pipe_sum + (pipe_addr ? (pipe_num << 1) : pipe_num);
        m2_x   <= m1_x;
        m2_num <= m1_num;
        m2_sum <= m1_sum;
        m3_x   <= m2_x;
        m3_num <= m2_num;
        m3_sum <= m2_sum;
    end

    assign pipe_out_x   = m3_x;
    assign pipe_out_num = m3_num;
    assign pipe_out_sum = m3_sum;
    assign pipe_ovf     = ovf_inject & pipe_sel_sum & ~pipe_addr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat_exp(input logic [31:0] raw,
                                            input logic ovf);
`ifdef PIPE_SERIES_SAT_EN
        if (ovf) return raw[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return raw;
    endfunction

    // Full operand with out_ready=1; n1_* are the expected pass-1 inputs.
    task automatic run_op(input logic [31:0] x, input logic [31:0] n1_num,
                          input logic [31:0] n1_sum, input logic [31:0] res,
                          input logic exp_ovf);
        in_valid  = 1'b1;
        in_x      = x;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_out_valid", 32'(out_valid), 32'd0);
            chk("run_sel_sum", 32'(pipe_sel_sum), 32'd1);
            chk("run_addr", 32'(pipe_addr), (k > 4) ? 32'd1 : 32'd0);
            chk("run_pipe_x", pipe_x, x);
            chk("run_pipe_num", pipe_num, (k > 4) ? n1_num : x);
            chk("run_pipe_sum", pipe_sum, (k > 4) ? n1_sum : 32'd0);
            tick();
        end
        chk("done_valid", 32'(out_valid), 32'd1);
        chk("done_result", out_result, res);
        chk("done_ovf", 32'(out_ovf), 32'(exp_ovf));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("after_valid", 32'(out_valid), 32'd0);
        chk("after_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_x       = '0;
        out_ready  = 1'b0;
        ovf_inject = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_sel_sum", 32'(pipe_sel_sum), 32'd0);
        chk("rst_pipe_x", pipe_x, 32'd0);
        rst_n = 1'b1;

        // Zero operand, then x=3 for addr/hold: pass 1 sees (3, 6, 3).
        run_op(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        run_op(32'd3, 32'd6, 32'd3, 32'd15, 1'b0);

        // Overflow injected on pass 0 only.
        ovf_inject = 1'b1;
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
               sat_exp(32'h7FFF_FFFB, 1'b1), 1'b1);
        run_op(32'h8000_0001, 32'h0000_0002, 32'h8000_0001,
               sat_exp(32'h8000_0005, 1'b1), 1'b1);
        ovf_inject = 1'b0;

        // in_valid held high: second accept right after the handshake.
        in_valid  = 1'b1;
        in_x      = 32'd1;
        out_ready = 1'b1;
        tick();
        in_x = 32'd9;
        for (int k = 1; k <= 8; k++) begin
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_pipe_x", pipe_x, 32'd1);
            tick();
        end
        chk("hold_done_valid", 32'(out_valid), 32'd1);
        chk("hold_done_result", out_result, 32'd5);
        chk("hold_done_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("hold_idle_in_ready", 32'(in_ready), 32'd1);
        chk("hold_idle_busy", 32'(busy), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("second_busy", 32'(busy), 32'd1);
        chk("second_pipe_x", pipe_x, 32'd9);
        chk("second_pipe_num", pipe_num, 32'd9);
        for (int k = 0; k < 8; k++) tick();
        chk("second_valid", 32'(out_valid), 32'd1);
        chk("second_result", out_result, 32'd45);
        tick();
        chk("second_consumed", 32'(out_valid), 32'd0);

        // Consumer stalls for 5 DONE cycles.
        in_valid  = 1'b1;
        in_x      = 32'd2;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", out_result, 32'd10);
            chk("stall_ovf", 32'(out_ovf), 32'd0);
            tick();
        end
        chk("stall_valid6", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("stall_released", 32'(out_valid), 32'd0);
        chk("stall_in_ready", 32'(in_ready), 32'd1);

        // Reset in RUN cycle 4 aborts the operand.
        in_valid   = 1'b1;
        in_x       = 32'd4;
        ovf_inject = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", out_result, 32'd0);
        rst_n      = 1'b1;
        ovf_inject = 1'b0;
        run_op(32'd5, 32'd10, 32'd5, 32'd25, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
